// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: state, opcode, funct and ALU encodings for the multicycle control FSM
package multi_cycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LW_WB   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXE   = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_JMP     = 4'd9,
    S_I_EXE   = 4'd10,
    S_I_WB    = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  function automatic state_t id_next(input logic [5:0] op, input logic r_legal);
    case (op)
      OP_R:             return r_legal ? S_R_EXE : S_IF;
      OP_LW, OP_SW:     return S_MEM_ADR;
      OP_BEQ:           return S_BEQ;
      OP_J:             return S_JMP;
      OP_ADDI, OP_SLTI: return S_I_EXE;
      default:          return S_IF;
    endcase
  endfunction
endpackage

// File: rtl/multi_cycle_ctrl_alu_decoder.sv
// alu_decoder: R-type funct to ALU operation, with legality and overflow-check flags
module alu_decoder
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       ovf_chk,
  output logic       legal
);
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_XOR:  alu_op = ALU_XOR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SRL:  alu_op = ALU_SRL;
      default: legal  = 1'b0;
    endcase
  end
  assign ovf_chk = (funct == FN_ADD) | (funct == FN_SUB);
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore control FSM sequencing the multicycle MIPS datapath
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        overflow,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [3:0]  state_out
);
  state_t     state_q, state_d;
  logic       ovf_q, ovf_d;
  logic [5:0] op;
  logic [2:0] r_alu_op;
  logic       r_ovf_chk, r_legal;
  logic       unused_zero;
  assign op = Inst[31:26];
  assign unused_zero = zero;
  alu_decoder u_dec (
    .funct   (Inst[5:0]),
    .alu_op  (r_alu_op),
    .ovf_chk (r_ovf_chk),
    .legal   (r_legal)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    if (MIO_ready) begin
      case (state_q)
        S_IF:      state_d = S_ID;
        S_ID:      state_d = id_next(op, r_legal);
        S_MEM_ADR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:  state_d = S_LW_WB;
        S_R_EXE:   state_d = S_R_WB;
        S_I_EXE:   state_d = S_I_WB;
        default:   state_d = S_IF;
      endcase
      ovf_d = (state_q == S_R_EXE) ? overflow & r_ovf_chk :
              (state_q == S_I_EXE) ? overflow & (op == OP_ADDI) :
              (state_q == S_IF)    ? 1'b0 : ovf_q;
    end
  end
  always_comb begin
    {MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch} = '0;
    {RegDst, MemtoReg, ALUSrcB, PCSource} = '0;
    ALU_operation = ALU_ADD;
    state_out     = state_q;
    case (state_q)
      S_IF: begin
        {MemRead, IRWrite, ALUSrcA, PCWrite} = '1;
        ALUSrcB = 2'b01;
      end
      S_ID: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b11;
      end
      S_MEM_ADR: ALUSrcB = 2'b10;
      S_MEM_RD:  {MemRead, IorD} = '1;
      S_LW_WB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEM_WR:  {MemWrite, IorD} = '1;
      S_R_EXE:   ALU_operation = r_alu_op;
      S_R_WB: begin
        RegDst   = 2'b01;
        RegWrite = !ovf_q;
      end
      S_BEQ: begin
        ALU_operation = ALU_SUB;
        {PCWriteCond, Branch} = '1;
        PCSource = 2'b01;
      end
      S_JMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_I_EXE: begin
        ALUSrcB       = 2'b10;
        ALU_operation = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB:  RegWrite = !ovf_q;
      default: ;
    endcase
    // a stalled bus must see no state-changing write strobes
    if (!MIO_ready) {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite} = '0;
    if (reset) begin
      {MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch} = '0;
      {RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation, state_out} = '0;
    end
  end
  assign CPU_MIO = MemRead | MemWrite;
endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Moore-style control FSM for the multicycle MIPS CPU. It sits directly upstream of the multicycle datapath and drives every datapath control input from the latched instruction word and the ALU `zero`/`overflow` flags. It sequences each instruction through IF/ID/EX/MEM/WB states and stalls whenever the memory/IO bus is not ready.

## Interface
Parameters:
- none; state, opcode and ALU-op encodings are fixed in `multi_cycle_ctrl_pkg`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `MIO_ready` in 1: memory/IO ready; 0 = stall.
- `Inst` in 32: current IR contents (opcode `[31:26]`, funct `[5:0]`).
- `zero` in 1: ALU zero flag.
- `overflow` in 1: ALU signed overflow flag.
- `MemRead`, `MemWrite` out 1: bus read/write strobes.
- `CPU_MIO` out 1: `MemRead | MemWrite`.
- `IorD`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCWrite`, `PCWriteCond`, `Branch` out 1: datapath controls.
- `RegDst`, `MemtoReg`, `ALUSrcB`, `PCSource` out 2: datapath mux selects.
- `ALU_operation` out 3: ALU op code.
- `state_out` out 4: current state, for debug.

## Operation
- ALU codes: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
- Supported instructions:
  - R-type (op 000000): funct add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, srl 000010.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000, slti 001010.
  - Any other opcode or funct is illegal: ID returns to IF and nothing is written.
- State encodings and outputs. Every output not listed is 0.
  - IF 0: MemRead, IorD=0, IRWrite, ALUSrcA=1, ALUSrcB=01, ADD, PCSource=00, PCWrite.
  - ID 1: ALUSrcA=1, ALUSrcB=11, ADD (branch target into ALUOut).
  - MEM_ADR 2: ALUSrcA=0, ALUSrcB=10, ADD.
  - MEM_RD 3: MemRead, IorD=1.
  - LW_WB 4: RegDst=00, MemtoReg=01, RegWrite.
  - MEM_WR 5: MemWrite, IorD=1.
  - R_EXE 6: ALUSrcA=0, ALUSrcB=00, ALU op from funct.
  - R_WB 7: RegDst=01, MemtoReg=00, RegWrite.
  - BEQ 8: ALUSrcA=0, ALUSrcB=00, SUB, PCWriteCond, Branch, PCSource=01.
  - JMP 9: PCSource=10, PCWrite.
  - I_EXE 10: ALUSrcA=0, ALUSrcB=10, ADD (addi) or SLT (slti).
  - I_WB 11: RegDst=00, MemtoReg=00, RegWrite.
- Transitions:
  - IF→ID.
  - ID→MEM_ADR for lw/sw; R_EXE for R-type; BEQ for beq; JMP for j; I_EXE for addi/slti; IF if illegal.
  - MEM_ADR→MEM_RD for lw, MEM_WR for sw.
  - MEM_RD→LW_WB.
  - R_EXE→R_WB.
  - I_EXE→I_WB.
  - LW_WB, MEM_WR, R_WB, BEQ, JMP, I_WB→IF.
- Overflow flag `ovf_q`:
  - Loaded on leaving R_EXE or I_EXE with `overflow & (add|sub|addi)`.
  - When set, it suppresses `RegWrite` in R_WB/I_WB.
  - Cleared in IF.
- `CPU_MIO = MemRead | MemWrite`.

## Timing
- Reset:
  - `reset`=1 at a rising edge: state←IF, `ovf_q`←0.
  - While `reset`=1, all outputs are forced to 0 combinationally.
  - Reset mid-instruction abandons it; no partial register or memory write occurs after the reset edge.
- Outputs are decoded from state (and latched `Inst`); no output depends on `zero`.
- Stall: with `MIO_ready`=0, state and `ovf_q` hold, and `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite` and `MemWrite` are forced to 0. Mux selects and read strobes stay asserted.
- Latency in cycles, no stalls: lw 5; sw, R-type, addi, slti 4; beq, j 3; illegal 2.
- Branch resolution is in the datapath (PC CE = `PCWriteCond & zero & Branch`). The FSM leaves BEQ regardless of `zero`.

## Structure
- `multi_cycle_ctrl_pkg` holds:
  - state enum (4-bit);
  - opcode and funct constants;
  - ALU_operation constants.
- Sub-module `alu_decoder`: combinational funct→ALU_operation. It also provides `ovf_chk` (add/sub) and `legal` flags; used in R_EXE and ID.
- Top level holds: state register, `ovf_q`, next-state logic, output decode, stall/reset gating.

## Test plan
- Reset held 3 cycles mid-MEM_RD → all outputs 0 during reset; `state_out`=0 after release; first cycle shows MemRead=1, PCWrite=1, ALUSrcB=01.
- lw (`Inst`=0x8C220004) → `state_out` sequence 0,1,2,3,4,0; LW_WB shows MemtoReg=01, RegWrite=1.
- R-type sub with `overflow`=1 in R_EXE → R_WB has RegWrite=0. Repeat with `overflow`=0 → RegWrite=1, RegDst=01, ALU_operation=110 in R_EXE.
- beq with `zero`=0 then `zero`=1 → both visit state 8 with PCWriteCond=1, Branch=1, PCSource=01, then return to 0. j → state 9, PCSource=10, PCWrite=1.
- `MIO_ready`=0 for 4 cycles in MEM_WR → `state_out` holds 5, MemWrite=0, CPU_MIO=0. On ready, MemWrite=1 for one cycle, then IF.
- Illegal opcode 0x3F → sequence 0,1,0, with RegWrite and MemWrite never asserted.
